// File: rtl/alu_4_bit_pkg.sv
// Shared opcode/width constants and the result bundle passed from the
// combinational core to the output registers.
package alu_4_bit_pkg;

  localparam int unsigned DW = 4;
  localparam int unsigned RW = 5;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef struct packed {
    logic [RW-1:0] op;
    logic          zero;
    logic          ovf;
  } alu_res_t;

endpackage

// File: rtl/alu_4_bit_core.sv
// Combinational opcode decode plus result and status-flag generation.
module alu_4_bit_core
  import alu_4_bit_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [1:0]    opcode,
  output alu_res_t      res
);

  logic [RW-1:0] sum;
  logic [RW-1:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    // Wraps mod 32, so bit 4 doubles as the borrow when a < b.
    diff = {1'b0, a} - {1'b0, b};
    res  = '0;
    unique case (opcode)
      OP_ADD: begin
        res.op  = sum;
        res.ovf = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        res.op  = diff;
        res.ovf = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
      OP_AND: res.op = {1'b0, a & b};
      OP_OR:  res.op = {1'b0, a | b};
      default: res = '0;
    endcase
    res.zero = (res.op == '0);
  end

endmodule

// File: rtl/alu_4_bit.sv
// Registered 4-bit ALU: one cycle of latency, result and flags hold while
// in_valid is low.
module alu_4_bit
  import alu_4_bit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [1:0]    opcode,
  output logic [RW-1:0] op,
  output logic          out_valid,
  output logic          zero,
  output logic          ovf
);

  alu_res_t res_d;
  alu_res_t res_q;
  logic     valid_q;

  alu_4_bit_core u_core (
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .res    (res_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q <= res_d;
      end
    end
  end

  assign op        = res_q.op;
  assign zero      = res_q.zero;
  assign ovf       = res_q.ovf;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_4_bit.sv
// Directed bench for alu_4_bit: expected results are queued when driven and
// popped when the registered output is sampled.
module tb_alu_4_bit;

  typedef struct packed {
    logic [4:0] op;
    logic       zero;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [1:0] opcode = '0;
  logic [4:0] op;
  logic       out_valid;
  logic       zero;
  logic       ovf;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t held = '0;

  always #5 clk = ~clk;

  alu_4_bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .op        (op),
    .out_valid (out_valid),
    .zero      (zero),
    .ovf       (ovf)
  );

  // Independent reference: integer arithmetic and signed range check.
  function automatic exp_t model(input logic [3:0] va, input logic [3:0] vb,
                                 input logic [1:0] opc);
    exp_t e;
    int   ua = int'(va);
    int   ub = int'(vb);
    int   sa = (ua >= 8) ? ua - 16 : ua;
    int   sb = (ub >= 8) ? ub - 16 : ub;
    int   r;
    int   sr;
    e = '0;
    case (opc)
      2'd0: begin
        r  = ua + ub;
        sr = sa + sb;
        e.ovf = (sr > 7) || (sr < -8);
      end
      2'd1: begin
        r  = (ua - ub + 32) % 32;
        sr = sa - sb;
        e.ovf = (sr > 7) || (sr < -8);
      end
      2'd2: r = int'(va & vb);
      default: r = int'(va | vb);
    endcase
    e.op   = r[4:0];
    e.zero = (r == 0);
    return e;
  endfunction

  task automatic chk1(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic v,
                      input logic [3:0] va, input logic [3:0] vb, input logic [1:0] opc);
    exp_t e;
    logic ev;
    @(negedge clk);
    rst = r;
    in_valid = v;
    a = va;
    b = vb;
    opcode = opc;
    if (v && !r) q.push_back(model(va, vb, opc));
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      held = '0;
      ev = 1'b0;
    end else if (v) begin
      ev = 1'b1;
      checks++;
      assert (q.size() > 0) else begin
        failures++;
        $error("FAIL %s_queue observed=empty expected=entry", tag);
      end
      if (q.size() > 0) held = q.pop_front();
    end else begin
      ev = 1'b0;
    end
    e = held;
    chk1({tag, "_valid"}, {4'b0, out_valid}, {4'b0, ev});
    chk1({tag, "_op"}, op, e.op);
    chk1({tag, "_zero"}, {4'b0, zero}, {4'b0, e.zero});
    chk1({tag, "_ovf"}, {4'b0, ovf}, {4'b0, e.ovf});
  endtask

  initial begin
    step("reset0", 1'b1, 1'b0, 4'h0, 4'h0, 2'd0);
    step("reset1", 1'b1, 1'b1, 4'h3, 4'h3, 2'd0);
    step("idle", 1'b0, 1'b0, 4'h0, 4'h0, 2'd0);
    step("add_4_13", 1'b0, 1'b1, 4'b0100, 4'b1101, 2'd0);
    chk1("add_4_13_lit", op, 5'b10001);
    step("sub_4_13", 1'b0, 1'b1, 4'b0100, 4'b1101, 2'd1);
    chk1("sub_4_13_lit", op, 5'b10111);
    step("sub_7_8", 1'b0, 1'b1, 4'b0111, 4'b1000, 2'd1);
    chk1("sub_7_8_lit", {op, ovf}, 6'b111111);
    step("and", 1'b0, 1'b1, 4'b0100, 4'b1101, 2'd2);
    chk1("and_lit", op, 5'b00100);
    step("or", 1'b0, 1'b1, 4'b0100, 4'b1101, 2'd3);
    chk1("or_lit", op, 5'b01101);
    step("add_zero", 1'b0, 1'b1, 4'h0, 4'h0, 2'd0);
    chk1("add_zero_lit", {op, zero}, 6'b000001);
    step("sub_zero", 1'b0, 1'b1, 4'b0101, 4'b0101, 2'd1);
    step("add_ovf", 1'b0, 1'b1, 4'b0111, 4'b0001, 2'd0);
    chk1("add_ovf_lit", {op, ovf}, 6'b010001);
    step("add_ff", 1'b0, 1'b1, 4'b1111, 4'b1111, 2'd0);
    chk1("add_ff_lit", {op, ovf}, 6'b111100);
    step("add_neg_ovf", 1'b0, 1'b1, 4'b1000, 4'b1000, 2'd0);
    step("sub_neg_ovf", 1'b0, 1'b1, 4'b1000, 4'b0001, 2'd1);
    step("hold_pre", 1'b0, 1'b1, 4'b0100, 4'b1101, 2'd0);
    step("hold", 1'b0, 1'b0, 4'b1010, 4'b0011, 2'd1);
    chk1("hold_lit", op, 5'b10001);
    step("hold2", 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd3);
    for (int i = 0; i < 16; i++) begin
      step("rand", 1'b0, 1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)),
           2'($urandom_range(3)));
    end
    step("rst_mid", 1'b1, 1'b1, 4'b1111, 4'b0001, 2'd0);
    step("after_rst", 1'b0, 1'b1, 4'b0010, 4'b0011, 2'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
